// File: rtl/sum_disp_pkg.sv
// Shared constants and types for the sum display scanner: segment table,
// blanking values, digit slot indices and the per-slot FSM encoding.
package sum_disp_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; entry n is HEX_SEG[n].
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef logic [1:0] dig_idx_t;

   localparam dig_idx_t DIG_A     = 2'd0;
   localparam dig_idx_t DIG_B     = 2'd1;
   localparam dig_idx_t DIG_TENS  = 2'd2;
   localparam dig_idx_t DIG_UNITS = 2'd3;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } state_t;

endpackage : sum_disp_pkg

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit to active-low 7-segment decoder, shared by
// display blocks.
module seg7_hex_dec
   import sum_disp_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   assign seg_n = HEX_SEG[hex];

endmodule : seg7_hex_dec

// File: rtl/sum_display_scan.sv
// Drives a 4-digit multiplexed common-anode display with A, B and the
// decimal adder sum; inputs are snapshotted once per frame.
module sum_display_scan
   import sum_disp_pkg::*;
#(
   parameter int NB        = 4,
   parameter int SCAN_DIV  = 12500,
   parameter int BLANK_CYC = 250
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NB-1:0] a_i,
   input  logic [NB-1:0] b_i,
   input  logic [NB-1:0] s_n_i,
   input  logic          co_n_i,
   output logic [3:0]    an_n_o,
   output logic [6:0]    seg_n_o,
   output logic          frame_tick_o
);

   localparam int             CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYC);
   // Slot 0 starts at count 0, which is already ON when there is no blanking.
   localparam state_t         ST_RESET  = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;

   logic [CW-1:0] cnt_q, cnt_d;
   dig_idx_t      idx_q;
   state_t        state_q, state_d;
   logic          wrap, frame_end;

   logic [NB-1:0] snap_a, snap_b;
   logic [NB:0]   snap_sum;
   logic          frame_tick_q;

   logic [1:0]    tens;
   logic [3:0]    units;
   logic [3:0]    digit;
   logic [6:0]    digit_seg;
   logic [3:0]    an_d, an_q;
   logic [6:0]    seg_d, seg_q;

   // ---------------- slot counter and digit index ----------------
   assign wrap      = (cnt_q == CNT_MAX);
   assign frame_end = wrap && (idx_q == DIG_UNITS);
   assign cnt_d     = wrap ? '0 : cnt_q + 1'b1;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= DIG_A;
         state_q <= ST_RESET;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         if (wrap) idx_q <= idx_q + 2'd1;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = ST_ON;
      if (cnt_d < CNT_BLANK) state_d = ST_BLANK;
   end

   // ---------------- per-frame snapshot ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_a       <= '0;
         snap_b       <= '0;
         snap_sum     <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= frame_end;
         if (frame_end) begin
            snap_a   <= a_i;
            snap_b   <= b_i;
            snap_sum <= {~co_n_i, ~s_n_i};
         end
      end
   end

   // Decimal split of 0..30 by range comparison.
   always_comb begin
      tens  = 2'd0;
      units = snap_sum[3:0];
      if (snap_sum >= 5'd30) begin
         tens  = 2'd3;
         units = 4'(snap_sum - 5'd30);
      end else if (snap_sum >= 5'd20) begin
         tens  = 2'd2;
         units = 4'(snap_sum - 5'd20);
      end else if (snap_sum >= 5'd10) begin
         tens  = 2'd1;
         units = 4'(snap_sum - 5'd10);
      end
   end

   always_comb begin
      digit = units;
      case (idx_q)
         DIG_A:    digit = snap_a;
         DIG_B:    digit = snap_b;
         DIG_TENS: digit = {2'b00, tens};
         default:  digit = units;
      endcase
   end

   seg7_hex_dec u_dec (
      .hex   (digit),
      .seg_n (digit_seg)
   );

   // ---------------- anode / segment outputs ----------------
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      // Leading-zero tens digit stays dark for its whole slot.
      if (state_q == ST_ON && !(idx_q == DIG_TENS && tens == 2'd0)) begin
         an_d  = ~(4'b1000 >> idx_q);
         seg_d = digit_seg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_BLANK;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign an_n_o       = an_q;
   assign seg_n_o      = seg_q;
   assign frame_tick_o = frame_tick_q;

endmodule : sum_display_scan

// File: doc/sum_display_scan.md
Name: sum_display_scan

Overview:
- Downstream consumer of the 4-bit ripple adder stage: takes operands A, B and the adder's active-low sum/carry outputs and drives a 4-digit multiplexed common-anode 7-segment display.
- Digits, left to right: A (hex), B (hex), sum tens (decimal), sum units (decimal).
- Inputs are snapshotted once per frame so a frame never mixes old and new values; anodes blank briefly at each slot start to suppress ghosting.

Parameters:
- NB, 4, operand/sum width; only 4 is supported.
- SCAN_DIV, 12500, clock cycles per digit slot (50 MHz → 4 kHz slot rate, 1 kHz frame rate); must be ≥ 2.
- BLANK_CYC, 250, cycles at the start of each slot with all anodes off; 0 ≤ BLANK_CYC < SCAN_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_i  in  NB  operand A, raw (active-high).
- b_i  in  NB  operand B, raw (active-high).
- s_n_i  in  NB  adder sum, active-low.
- co_n_i  in  1  adder carry out, active-low.
- an_n_o  out  4  digit anodes, active-low; an_n_o[3]=A, [2]=B, [1]=tens, [0]=units.
- seg_n_o  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- frame_tick_o  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - an_n_o=4'b1111, seg_n_o=7'h7F, frame_tick_o=0.
  - Slot counter=0, digit index=0.
  - Snapshot registers hold A=0, B=0, sum=0.
  - Reset assertion mid-slot forces these values immediately, without waiting for a clock edge.
- Slot counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, the digit index advances 0→1→2→3→0.
  - Index 0 drives an[3], 1 drives an[2], 2 drives an[1], 3 drives an[0].
- Per-slot FSM, two states:
  - BLANK: count < BLANK_CYC. All anodes high; seg_n_o=7'h7F.
  - ON: count ≥ BLANK_CYC. The selected anode is low and seg_n_o carries its digit pattern.
  - If BLANK_CYC=0, the slot is ON for its entire duration.
- Snapshot:
  - Taken on the edge where count==SCAN_DIV-1 and index==3, i.e. the same edge that moves the index back to 0.
  - Captures a_i, b_i and sum5 = {~co_n_i, ~s_n_i}; sum5 ranges 0..30.
  - frame_tick_o is high for exactly the cycle after that edge.
  - Input changes between snapshots do not affect the display.
  - The first frame after reset shows the reset snapshot: A "0", B "0", tens blank, units "0".
- Decimal split:
  - tens = 3 if sum5 ≥ 30, 2 if ≥ 20, 1 if ≥ 10, else 0.
  - units = sum5 − 10·tens.
  - Implemented with comparators; no divider.
- Leading-zero blanking: when tens==0, an[1] stays high for the whole tens slot and seg_n_o=7'h7F during it.
- Segment decode:
  - Hex 0–F, active-low.
  - 0=7'h40, 1=7'h79, 3=7'h30, 7=7'h78, 8=7'h00, 9=7'h10, F=7'h0E; other codes use the standard hex patterns.
- Output registering:
  - an_n_o and seg_n_o are registered, so outputs follow the count/index by one cycle.
  - At most one anode is low in any cycle.
- Values of s_n_i/co_n_i that are inconsistent with a_i+b_i are displayed as received; no checking is done.

Decomposition:
- Shared package sum_disp_pkg holds:
  - the 16-entry active-low hex-to-segment constant table;
  - SEG_BLANK=7'h7F and AN_OFF=4'hF;
  - digit index constants DIG_A=0, DIG_B=1, DIG_TENS=2, DIG_UNITS=3;
  - the FSM state encoding ST_BLANK / ST_ON.
- One combinational sub-module, seg7_hex_dec: 4-bit in, 7-bit active-low out. It is reused by future display blocks.

Test Plan (SCAN_DIV=8, BLANK_CYC=2; frame = 32 cycles):
- Reset held, then released → an_n_o=1111, seg_n_o=7'h7F. After release, an_n_o stays all-high for the first 2 cycles (BLANK) of slot 0, then the pattern for A=0 appears.
- a=9, b=8, s_n=4'b1110, co_n=0, wait for frame_tick → per frame:
  - an[3] low for 6 cycles with seg 7'h10;
  - an[2] with 7'h00;
  - an[1] with 7'h79;
  - an[0] with 7'h78.
- a=3, b=4, s_n=4'b1000, co_n=1 (sum 7) → an[1] never low across a full frame; units slot shows 7'h78.
- a=F, b=F, s_n=4'b0001, co_n=0 (sum 30) → A and B slots show 7'h0E, tens slot 7'h30, units slot 7'h40.
- Change a_i mid-frame → displayed A is unchanged until the cycle after the next frame_tick; frame_tick pulses exactly once per 32 cycles.
- Assert rst_n low during an ON phase → an_n_o=1111 and seg_n_o=7'h7F before the next clock edge. After release, the index restarts at 0.
